// File: rtl/amdc_encoder_pkg.sv
// Shared types and Gray-code step decoding for the encoder quadrature decoder.
// Latency: combinational helpers only.
// Backpressure: none.
package amdc_encoder_pkg;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_FWD,
        STEP_REV,
        STEP_ILLEGAL
    } step_t;

    typedef enum logic {
        INIT,
        RUN
    } fsm_t;

    // Forward rotation visits {A,B} in this order.
    localparam logic [1:0] GRAY_0 = 2'b00;
    localparam logic [1:0] GRAY_1 = 2'b01;
    localparam logic [1:0] GRAY_2 = 2'b11;
    localparam logic [1:0] GRAY_3 = 2'b10;

    function automatic logic [1:0] gray_index(input logic [1:0] ab);
        logic [1:0] idx;
        idx = 2'd0;
        case (ab)
            GRAY_0:  idx = 2'd0;
            GRAY_1:  idx = 2'd1;
            GRAY_2:  idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    // Distance around the Gray cycle: 1 = forward, 3 = reverse, 2 = both bits flipped.
    function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] diff;
        step_t      step;
        diff = gray_index(cur) - gray_index(prev);
        case (diff)
            2'd0:    step = STEP_NONE;
            2'd1:    step = STEP_FWD;
            2'd3:    step = STEP_REV;
            default: step = STEP_ILLEGAL;
        endcase
        return step;
    endfunction

endpackage

// File: rtl/amdc_encoder_input_filter.sv
// Synchroniser plus debounce for one asynchronous encoder pin.
// Latency: SYNC_STAGES + FILT_LEN cycles from first sampling edge to filt change.
// Backpressure: none; free-running.
module amdc_encoder_input_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic ACLK,
    input  logic ARESET,
    input  logic pin,
    output logic filt
);
    localparam int CW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          run_cnt;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            sync_q  <= '0;
            run_cnt <= '0;
            filt    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            // run_cnt holds how many consecutive prior cycles synced differed from filt
            if (synced == filt) begin
                run_cnt <= '0;
            end else if (run_cnt == CW'(FILT_LEN - 1)) begin
                filt    <= synced;
                run_cnt <= '0;
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/amdc_encoder_quad_decoder.sv
// 4x quadrature decoder: filtered A/B/Z to signed count, wrapped position and sticky status.
// Latency: pin edge to count/position/step_pulse is SYNC_STAGES+FILT_LEN+1 cycles.
// Backpressure: none; every decoded step is applied on the cycle it is seen.
module amdc_encoder_quad_decoder
    import amdc_encoder_pkg::*;
#(
    parameter int CNT_WIDTH   = 32,
    parameter int POS_WIDTH   = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 enc_a,
    input  logic                 enc_b,
    input  logic                 enc_z,
    input  logic                 cfg_enable,
    input  logic                 cfg_dir_invert,
    input  logic [POS_WIDTH-1:0] cfg_ppr_m1,
    input  logic                 count_clear,
    input  logic                 status_clear,
    output logic [CNT_WIDTH-1:0] count,
    output logic [POS_WIDTH-1:0] position,
    output logic                 dir,
    output logic                 step_pulse,
    output logic                 index_seen,
    output logic                 err_illegal
);
    localparam int INIT_LAST = SYNC_STAGES + FILT_LEN;
    localparam int IW        = $clog2(INIT_LAST + 1);

    logic filt_a, filt_b, filt_z;
    logic [1:0] cur_ab, prev_ab;
    logic prev_z;
    logic [IW-1:0] init_cnt;
    fsm_t state_q, state_d;
    step_t step;
    logic init_done, z_rise;
    logic do_step, step_fwd, illegal;
    logic [POS_WIDTH-1:0] pos_stepped;

    amdc_encoder_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
        .ACLK(ACLK), .ARESET(ARESET), .pin(enc_a), .filt(filt_a)
    );
    amdc_encoder_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
        .ACLK(ACLK), .ARESET(ARESET), .pin(enc_b), .filt(filt_b)
    );
    amdc_encoder_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_z (
        .ACLK(ACLK), .ARESET(ARESET), .pin(enc_z), .filt(filt_z)
    );

    assign cur_ab = {filt_a, filt_b};

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // INIT waits one cycle past the filter fill so prev_ab captures settled pins.
    always_comb begin
        state_d   = state_q;
        init_done = 1'b0;
        step      = STEP_NONE;
        z_rise    = 1'b0;
        case (state_q)
            INIT: begin
                if (init_cnt == IW'(INIT_LAST)) begin
                    state_d   = RUN;
                    init_done = 1'b1;
                end
            end
            RUN: begin
                step   = decode_step(prev_ab, cur_ab);
                z_rise = filt_z & ~prev_z;
            end
            default: state_d = INIT;
        endcase
    end

    assign do_step  = cfg_enable & ((step == STEP_FWD) | (step == STEP_REV));
    assign step_fwd = (step == STEP_FWD) ^ cfg_dir_invert;
    assign illegal  = (step == STEP_ILLEGAL);

    always_comb begin
        pos_stepped = position;
        if (position > cfg_ppr_m1) begin
            pos_stepped = '0;
        end else if (step_fwd) begin
            pos_stepped = (position == cfg_ppr_m1) ? '0 : position + 1'b1;
        end else begin
            pos_stepped = (position == '0) ? cfg_ppr_m1 : position - 1'b1;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            init_cnt    <= '0;
            prev_ab     <= '0;
            prev_z      <= 1'b0;
            count       <= '0;
            position    <= '0;
            dir         <= 1'b0;
            step_pulse  <= 1'b0;
            index_seen  <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            if (state_q == INIT && !init_done) begin
                init_cnt <= init_cnt + 1'b1;
            end
            if (init_done || state_q == RUN) begin
                prev_ab <= cur_ab;
            end
            prev_z     <= filt_z;
            step_pulse <= do_step;
            if (do_step) begin
                dir <= step_fwd;
            end
            if (count_clear) begin
                count    <= '0;
                position <= '0;
            end else begin
                if (do_step) begin
                    count <= step_fwd ? count + 1'b1 : count - 1'b1;
                end
                if (z_rise && cfg_enable) begin
                    position <= '0;
                end else if (do_step) begin
                    position <= pos_stepped;
                end
            end
            if (illegal) begin
                err_illegal <= 1'b1;
            end else if (status_clear) begin
                err_illegal <= 1'b0;
            end
            if (z_rise) begin
                index_seen <= 1'b1;
            end else if (status_clear) begin
                index_seen <= 1'b0;
            end
        end
    end

endmodule
